// File: rtl/bcd_serial_deser.sv
// rtl/bcd_serial_deser.sv - serial bit stream to BCD digit deserializer with one-digit output holding register
module bcd_serial_deser #(
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_bit,
    input  logic             in_bit_valid,
    output logic             out_bit_ready,
    input  logic             in_ready,
    output logic             out_A,
    output logic             out_B,
    output logic             out_C,
    output logic             out_D,
    output logic             out_valid,
    output logic             out_err,
    output logic [CNT_W-1:0] out_digit_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sr_q, sr_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [3:0]       dig_q, dig_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       code;
    logic             accept;
    logic             complete;
    logic             code_ok;
    logic             load;
    logic             deliver;

    // The three earlier bits sit in sr_q; the completing bit is merged combinationally.
    assign code = (MSB_FIRST != 0) ? {sr_q, in_bit} : {in_bit, sr_q};

    // Only the completing bit can stall, and only when the holding register cannot drain.
    assign out_bit_ready = !in_rst && !((bcnt_q == 2'd3) && (state_q == FULL) && !in_ready);

    assign accept   = in_bit_valid && out_bit_ready;
    assign complete = accept && (bcnt_q == 2'd3);
    assign code_ok  = (code <= 4'd9);
    assign load     = complete && code_ok;
    assign deliver  = (state_q == FULL) && in_ready;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcnt_d  = bcnt_q;
        dig_d   = dig_q;
        err_d   = complete && !code_ok;
        cnt_d   = cnt_q;

        if (accept) begin
            bcnt_d = bcnt_q + 2'd1;
            sr_d   = (MSB_FIRST != 0) ? {sr_q[1:0], in_bit} : {in_bit, sr_q[2:1]};
        end

        if (deliver) begin
            state_d = EMPTY;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end

        // A load at the delivery edge keeps the register full with no bubble.
        if (load) begin
            state_d = FULL;
            dig_d   = code;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= EMPTY;
            sr_q    <= 3'd0;
            bcnt_q  <= 2'd0;
            dig_q   <= 4'd0;
            err_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            dig_q   <= dig_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_A         = dig_q[3];
    assign out_B         = dig_q[2];
    assign out_C         = dig_q[1];
    assign out_D         = dig_q[0];
    assign out_valid     = (state_q == FULL);
    assign out_err       = err_q;
    assign out_digit_cnt = cnt_q;

endmodule

// File: tb/tb_bcd_serial_deser.sv
// tb/tb_bcd_serial_deser.sv - scoreboard bench: MSB-first, LSB-first and narrow-counter instances
module tb_bcd_serial_deser;

    logic       in_clk;
    logic       in_rst;
    logic       bit_i     [3];
    logic       bit_valid [3];
    logic       ready_i   [3];
    logic       bit_ready [3];
    logic       oa [3];
    logic       ob [3];
    logic       oc [3];
    logic       od [3];
    logic       ov [3];
    logic       oe [3];
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;
    logic [7:0] cnt_v [3];

    logic [3:0] exp_q [3][$];
    int         model_cnt [3];
    int         n_checks;
    int         n_fail;

    assign cnt_v[0] = cnt0;
    assign cnt_v[1] = cnt1;
    assign cnt_v[2] = {6'd0, cnt2};

    bcd_serial_deser #(.MSB_FIRST(1), .CNT_W(8)) dut_msb (
        .in_clk(in_clk), .in_rst(in_rst), .in_bit(bit_i[0]), .in_bit_valid(bit_valid[0]),
        .out_bit_ready(bit_ready[0]), .in_ready(ready_i[0]),
        .out_A(oa[0]), .out_B(ob[0]), .out_C(oc[0]), .out_D(od[0]),
        .out_valid(ov[0]), .out_err(oe[0]), .out_digit_cnt(cnt0)
    );

    bcd_serial_deser #(.MSB_FIRST(0), .CNT_W(8)) dut_lsb (
        .in_clk(in_clk), .in_rst(in_rst), .in_bit(bit_i[1]), .in_bit_valid(bit_valid[1]),
        .out_bit_ready(bit_ready[1]), .in_ready(ready_i[1]),
        .out_A(oa[1]), .out_B(ob[1]), .out_C(oc[1]), .out_D(od[1]),
        .out_valid(ov[1]), .out_err(oe[1]), .out_digit_cnt(cnt1)
    );

    bcd_serial_deser #(.MSB_FIRST(1), .CNT_W(2)) dut_sat (
        .in_clk(in_clk), .in_rst(in_rst), .in_bit(bit_i[2]), .in_bit_valid(bit_valid[2]),
        .out_bit_ready(bit_ready[2]), .in_ready(ready_i[2]),
        .out_A(oa[2]), .out_B(ob[2]), .out_C(oc[2]), .out_D(od[2]),
        .out_valid(ov[2]), .out_err(oe[2]), .out_digit_cnt(cnt2)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] abcd(input int d);
        return {oa[d], ob[d], oc[d], od[d]};
    endfunction

    // Deliveries happen at the next rising edge; inputs are stable at the falling edge.
    always @(negedge in_clk) begin
        if (!in_rst) begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && ready_i[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check_eq($sformatf("unexpected_digit%0d", d), 32'(abcd(d)), 32'hx);
                    end else begin
                        check_eq($sformatf("deliver%0d", d), 32'(abcd(d)), 32'(exp_q[d].pop_front()));
                    end
                    check_eq($sformatf("cnt_pre%0d", d), 32'(cnt_v[d]), 32'(model_cnt[d]));
                    if (model_cnt[d] < ((d == 2) ? 3 : 255)) model_cnt[d]++;
                end
            end
        end
    end

    task automatic do_reset();
        in_rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) check_eq($sformatf("rst_bit_ready%0d", d), 32'(bit_ready[d]), 32'd0);
        @(posedge in_clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("rst_outs%0d", d), 32'({abcd(d), ov[d], oe[d]}), 32'd0);
            check_eq($sformatf("rst_cnt%0d", d), 32'(cnt_v[d]), 32'd0);
            exp_q[d].delete();
            model_cnt[d] = 0;
        end
        in_rst = 1'b0;
    endtask

    task automatic send_bit(input int d, input logic b);
        bit accepted;
        int n;
        accepted = 1'b0;
        n = 0;
        bit_i[d] = b;
        bit_valid[d] = 1'b1;
        while (!accepted && n < 20) begin
            @(negedge in_clk);
            accepted = bit_ready[d];
            @(posedge in_clk);
            #1;
            n++;
        end
        bit_valid[d] = 1'b0;
        if (!accepted) check_eq($sformatf("bit_timeout%0d", d), 32'd0, 32'd1);
    endtask

    // code is given as ABCD; instance 1 receives it D first.
    task automatic send_digit(input int d, input logic [3:0] code);
        for (int i = 0; i < 4; i++) send_bit(d, (d == 1) ? code[i] : code[3-i]);
        if (code <= 4'd9) begin
            check_eq($sformatf("load_valid%0d", d), 32'(ov[d]), 32'd1);
            check_eq($sformatf("load_abcd%0d", d), 32'(abcd(d)), 32'(code));
            check_eq($sformatf("load_noerr%0d", d), 32'(oe[d]), 32'd0);
            exp_q[d].push_back(code);
        end else begin
            check_eq($sformatf("err_pulse%0d", d), 32'(oe[d]), 32'd1);
            check_eq($sformatf("err_novalid%0d", d), 32'(ov[d]), 32'd0);
            @(posedge in_clk);
            #1;
            check_eq($sformatf("err_end%0d", d), 32'(oe[d]), 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int d = 0; d < 3; d++) begin
            bit_i[d] = 1'b0;
            bit_valid[d] = 1'b0;
            ready_i[d] = 1'b0;
            model_cnt[d] = 0;
        end
        in_rst = 1'b1;
        repeat (2) @(posedge in_clk);
        do_reset();

        // Basic MSB-first digit delivered immediately.
        ready_i[0] = 1'b1;
        send_digit(0, 4'b0110);
        @(posedge in_clk);
        #1;
        check_eq("t1_cnt", 32'(cnt0), 32'd1);
        check_eq("t1_drained", 32'(ov[0]), 32'd0);

        // Non-BCD code is discarded.
        send_digit(0, 4'b1011);
        check_eq("t2_cnt", 32'(cnt0), 32'd1);

        // Completing bit stalls while the held digit cannot drain.
        ready_i[0] = 1'b0;
        send_digit(0, 4'b0101);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        bit_i[0] = 1'b1;
        bit_valid[0] = 1'b1;
        exp_q[0].push_back(4'b0011);
        repeat (3) begin
            @(negedge in_clk);
            check_eq("t3_stall", 32'(bit_ready[0]), 32'd0);
            check_eq("t3_hold", 32'({ov[0], abcd(0)}), 32'h15);
        end
        @(posedge in_clk);
        #1;
        ready_i[0] = 1'b1;
        @(negedge in_clk);
        check_eq("t3_release", 32'(bit_ready[0]), 32'd1);
        @(posedge in_clk);
        #1;
        bit_valid[0] = 1'b0;
        check_eq("t3_nobubble", 32'({ov[0], abcd(0)}), 32'h13);
        check_eq("t3_cnt", 32'(cnt0), 32'd2);

        // Partial digit is discarded by reset.
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        do_reset();
        ready_i[0] = 1'b1;
        send_digit(0, 4'b1001);

        // Back-to-back digits.
        send_digit(0, 4'b1000);
        send_digit(0, 4'b0111);
        send_digit(0, 4'b0000);

        // LSB-first instance.
        ready_i[1] = 1'b1;
        send_digit(1, 4'b0001);
        send_digit(1, 4'b0111);
        send_digit(1, 4'b1100);
        send_digit(1, 4'b1001);

        // Saturating narrow counter.
        ready_i[2] = 1'b1;
        for (int v = 0; v < 5; v++) send_digit(2, 4'(v));
        repeat (3) @(posedge in_clk);
        #1;
        check_eq("t6_sat", 32'(cnt2), 32'd3);
        check_eq("t0_final_cnt", 32'(cnt0), 32'd4);

        for (int d = 0; d < 3; d++) check_eq($sformatf("sb_empty%0d", d), 32'(exp_q[d].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
